mux_8x1: RTL and testbench

MUX_8X1 -- requirements
Module: mux_8x1

---
 rtl/mux_8x1.sv | 69 ++++++
 tb/tb_mux_8x1.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_8x1.sv
// mux_8x1: registered 8-to-1 multiplexer.
// Picks one of eight WIDTH-bit data inputs using a 3-bit select and
// captures it into an output register on enabled clock edges.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears out and out_valid)
//   i0..i7     data inputs, WIDTH bits each
//   s0,s1,s2   select bits, s2 is the MSB
//   en         capture enable
//   out        registered selected data
//   out_valid  high for the cycle following each enabled capture
module mux_8x1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int unsigned SEL_W = 3;

  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] d;

  assign sel = {s2, s1, s0};

  // Whole-word select; an unresolved select falls to the default arm.
  always_comb begin
    d = '0;
    case (sel)
      3'd0:    d = i0;
      3'd1:    d = i1;
      3'd2:    d = i2;
      3'd3:    d = i3;
      3'd4:    d = i4;
      3'd5:    d = i5;
      3'd6:    d = i6;
      3'd7:    d = i7;
      default: d = '0;
    endcase
  end

  // Capture register; out holds when en is low, valid tracks en one cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) begin
        out <= d;
      end
    end
  end

endmodule

// File: tb/tb_mux_8x1.sv
// Bench for mux_8x1: a 1-bit instance driven with spec-directed constants
// and an 8-bit instance checked against a small reference model, both
// scored through an expected-result queue popped one cycle after each drive.
module tb_mux_8x1;

  typedef struct {
    string      tag;
    logic       e1;
    logic [7:0] e8;
    logic       ev;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       s0, s1, s2;
  logic       a [8];
  logic [7:0] b [8];
  logic       out1, out_valid1;
  logic [7:0] out8;
  logic       out_valid8;
  logic [7:0] model8;

  int checks   = 0;
  int failures = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mux_8x1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .i0(a[0]), .i1(a[1]), .i2(a[2]), .i3(a[3]),
    .i4(a[4]), .i5(a[5]), .i6(a[6]), .i7(a[7]),
    .s0(s0), .s1(s1), .s2(s2), .en(en),
    .out(out1), .out_valid(out_valid1)
  );

  mux_8x1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .i0(b[0]), .i1(b[1]), .i2(b[2]), .i3(b[3]),
    .i4(b[4]), .i5(b[5]), .i6(b[6]), .i7(b[7]),
    .s0(s0), .s1(s1), .s2(s2), .en(en),
    .out(out8), .out_valid(out_valid8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare both instances against it.
  task automatic score();
    exp_t e;
    checks++;
    assert (sbq.size() > 0)
    else begin
      failures++;
      $error("FAIL sb_empty observed=%0d expected=1", sbq.size());
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.tag, "_out1"},   8'(out1),       8'(e.e1));
      chk({e.tag, "_out8"},   out8,           e.e8);
      chk({e.tag, "_valid1"}, 8'(out_valid1), 8'(e.ev));
      chk({e.tag, "_valid8"}, 8'(out_valid8), 8'(e.ev));
    end
  endtask

  // Drive one step at the falling edge, queue its expectation, score after the rise.
  task automatic cycle(input string tag, input logic e, input logic [2:0] sel, input logic x1);
    @(negedge clk);
    en = e;
    {s2, s1, s0} = sel;
    if (e) model8 = b[sel];
    sbq.push_back('{tag, x1, model8, e});
    @(posedge clk);
    #1;
    score();
  endtask

  task automatic set_a_onehot(input int k);
    for (int j = 0; j < 8; j++) a[j] = (j == k);
  endtask

  task automatic set_b_rand();
    for (int j = 0; j < 8; j++) b[j] = 8'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out1"},   8'(out1),       8'h00);
    chk({tag, "_out8"},   out8,           8'h00);
    chk({tag, "_valid1"}, 8'(out_valid1), 8'h00);
    chk({tag, "_valid8"}, 8'(out_valid8), 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    {s2, s1, s0} = 3'd7;
    for (int j = 0; j < 8; j++) begin
      a[j] = 1'b1;
      b[j] = 8'hFF;
    end
    model8 = 8'h00;

    // Reset state, with enabled edges arriving during reset.
    @(posedge clk);
    #1;
    chk_zero("reset");
    @(posedge clk);
    #1;
    chk_zero("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    // Walking one on the 1-bit instance; 0x10..0x17 sweep on the 8-bit one.
    for (int j = 0; j < 8; j++) b[j] = 8'h10 + 8'(j);
    for (int k = 0; k < 8; k++) begin
      set_a_onehot(k);
      cycle("walk", 1'b1, 3'(k), 1'b1);
    end

    // All-zero data at sel=0.
    set_a_onehot(8);
    for (int j = 0; j < 8; j++) b[j] = 8'h00;
    cycle("zero", 1'b1, 3'd0, 1'b0);

    // Isolation: unselected inputs must not leak.
    for (int j = 0; j < 8; j++) a[j] = 1'b1;
    a[3] = 1'b0;
    set_b_rand();
    cycle("iso3", 1'b1, 3'd3, 1'b0);
    set_a_onehot(2);
    set_b_rand();
    cycle("iso5", 1'b1, 3'd5, 1'b0);

    // Enable hold: capture a one, then three disabled cycles with new data/select.
    set_a_onehot(6);
    set_b_rand();
    cycle("cap6", 1'b1, 3'd6, 1'b1);
    a[6] = 1'b0;
    set_b_rand();
    for (int k = 0; k < 3; k++) cycle("hold", 1'b0, 3'd1, 1'b1);

    // Latency: select moves 2 -> 4 between edges; out waits for the next enabled edge.
    set_a_onehot(2);
    set_b_rand();
    cycle("lat_a", 1'b1, 3'd2, 1'b1);
    {s2, s1, s0} = 3'd4;
    #3;
    chk("lat_mid_out1", 8'(out1), 8'h01);
    chk("lat_mid_out8", out8, model8);
    cycle("lat_b", 1'b1, 3'd4, 1'b0);

    // Mid-stream asynchronous reset with en still high.
    set_a_onehot(5);
    set_b_rand();
    cycle("pre_rst", 1'b1, 3'd5, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("rst_edge");
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    model8 = 8'h00;
    cycle("post_rst", 1'b1, 3'd5, 1'b1);

    // Final WIDTH=8 sweep with back-to-back enables.
    for (int j = 0; j < 8; j++) b[j] = 8'h10 + 8'(j);
    for (int k = 0; k < 8; k++) begin
      set_a_onehot(7 - k);
      cycle("sweep8", 1'b1, 3'(k), 1'b0);
    end

    checks++;
    assert (sbq.size() == 0)
    else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
